bits_gather: RTL and testbench

- Serial-to-parallel inverse of the modulator's bit-flattening stage, placed on the demodulator side.
- Collects N serial bits, arriving at the 2.048 MHz strobe rate and LSB first, into one symbol word per 1.024 MHz strobe period.
- Each symbol starts on the sample coincident with ce_1M.
- Also provides a bypass mode (one bit per 1M strobe) and flags framing errors, counting them in a saturating counter.

---
 rtl/bits_gather_if.sv | 26 ++
 rtl/bits_gather.sv | 141 ++++++++++++++
 tb/tb_bits_gather.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/bits_gather_if.sv
// Strobe, serial-input and symbol-output bundle for bits_gather.
// master drives strobes and serial bits; slave is the gatherer.
interface bits_gather_if #(
  parameter int M     = 8,
  parameter int ERR_W = 8
);
  logic             ce_1M;
  logic             ce_2M;
  logic             bypass;
  logic             I;
  logic             I_vld;
  logic [M-1:0]     O;
  logic             O_vld;
  logic             err;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output ce_1M, ce_2M, bypass, I, I_vld,
    input  O, O_vld, err, err_cnt
  );

  modport slave (
    input  ce_1M, ce_2M, bypass, I, I_vld,
    output O, O_vld, err, err_cnt
  );
endinterface

// File: rtl/bits_gather.sv
// Serial-to-parallel symbol gatherer: N LSB-first bits at the 2M strobe form one
// M-bit word per 1M period, with a one-bit bypass path and framing-error counting.
module bits_gather #(
  parameter int N                = 2,
  parameter int M                = 8,
  parameter int BYPASS_SELECTION = 1,
  parameter int ERR_W            = 8
) (
  input  logic         clk,
  input  logic         rst,
  bits_gather_if.slave bus
);

  localparam int CW = $clog2(N + 1);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     sh_q, sh_d;
  logic [M-1:0]     o_q, o_d;
  logic             o_vld_q, o_vld_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic          sample;
  logic          start;
  logic          load;
  logic [N-1:0]  sh_n;
  logic [CW-1:0] cnt_n;

  assign sample = bus.ce_2M & bus.I_vld;
  assign start  = sample & bus.ce_1M;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    o_d       = o_q;
    o_vld_d   = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    load      = 1'b0;
    sh_n      = sh_q;
    cnt_n     = cnt_q;

    if (bus.bypass) begin
      // Bypass holds the collector idle, so leaving bypass drops any partial symbol silently.
      state_d = IDLE;
      cnt_d   = '0;
      sh_d    = '0;
      if (start) begin
        o_d                   = '0;
        o_d[BYPASS_SELECTION] = bus.I;
        o_vld_d               = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sh_n    = '0;
            sh_n[0] = bus.I;
            cnt_n   = CW'(1);
            load    = 1'b1;
          end else if (sample) begin
            err_d = 1'b1;
          end
        end
        COLLECT: begin
          if (start) begin
            err_d   = 1'b1;
            sh_n    = '0;
            sh_n[0] = bus.I;
            cnt_n   = CW'(1);
            load    = 1'b1;
          end else if (sample) begin
            for (int unsigned i = 0; i < N; i++) begin
              if (i == 32'(cnt_q)) sh_n[i] = bus.I;
            end
            cnt_n = CW'(32'(cnt_q) + 1);
            load  = 1'b1;
          end else if (bus.ce_2M) begin
            err_d   = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
            sh_d    = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          sh_d    = '0;
        end
      endcase

      // Completion is judged on the post-sample count, so N=1 finishes on the start sample.
      if (load) begin
        if (32'(cnt_n) == N) begin
          o_d     = M'(sh_n);
          o_vld_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
          sh_d    = '0;
        end else begin
          state_d = COLLECT;
          cnt_d   = cnt_n;
          sh_d    = sh_n;
        end
      end
    end

    if (err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      o_q       <= '0;
      o_vld_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      o_q       <= o_d;
      o_vld_q   <= o_vld_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.O       = o_q;
  assign bus.O_vld   = o_vld_q;
  assign bus.err     = err_q;
  assign bus.err_cnt = err_cnt_q;

endmodule

// File: tb/tb_bits_gather.sv
// Directed bench for bits_gather (N=2, M=8, BYPASS_SELECTION=1, ERR_W=2) with an
// output scoreboard: expected symbols/errors are queued at stimulus time.
module tb_bits_gather;

  typedef struct packed {
    logic       is_err;
    logic [7:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] ph  = '0;
  int         checks = 0;
  int         errors = 0;
  exp_t       q[$];
  exp_t       mon_e;

  bits_gather_if #(.M(8), .ERR_W(2)) bus ();

  bits_gather #(
    .N(2),
    .M(8),
    .BYPASS_SELECTION(1),
    .ERR_W(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #15 clk = ~clk;

  // ce_2M every 16 clk, ce_1M every 32 clk, aligned at phase 0.
  always @(posedge clk) ph <= ph + 5'd1;
  assign bus.ce_2M = (ph[3:0] == 4'd0);
  assign bus.ce_1M = (ph == 5'd0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_data(input logic [7:0] v);
    q.push_back('{is_err: 1'b0, val: v});
  endtask

  task automatic push_err();
    q.push_back('{is_err: 1'b1, val: 8'h00});
  endtask

  // Drive one ce_2M slot (aligned = the one coinciding with ce_1M).
  task automatic slot(input bit aligned, input logic v, input logic b);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (bus.ce_2M && (bus.ce_1M == aligned)) found = 1'b1;
    end
    if (!found) begin
      chk("slot_timeout", 32'd0, 32'd1);
    end else begin
      bus.I     = b;
      bus.I_vld = v;
      @(posedge clk);
      #1;
      bus.I_vld = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.err) begin
        if (q.size() == 0) chk("spurious_err", 32'd1, 32'd0);
        else begin
          mon_e = q.pop_front();
          chk("err_expected", 32'(mon_e.is_err), 32'd1);
        end
      end
      if (bus.O_vld) begin
        if (q.size() == 0) chk("spurious_vld", 32'd1, 32'd0);
        else begin
          mon_e = q.pop_front();
          chk("vld_expected", 32'(mon_e.is_err), 32'd0);
          chk("O_value", 32'(bus.O), 32'(mon_e.val));
        end
      end
    end
  end

  initial begin
    bus.bypass = 1'b0;
    bus.I      = 1'b0;
    bus.I_vld  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_O", 32'(bus.O), 32'h00);
    chk("rst_O_vld", 32'(bus.O_vld), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    rst = 1'b0;

    // Normal: (1,0) -> 01, then (0,1) -> 02
    slot(1'b1, 1'b1, 1'b1);
    push_data(8'h01);
    slot(1'b0, 1'b1, 1'b0);
    chk("latency_vld_01", 32'(bus.O_vld), 32'd1);
    slot(1'b1, 1'b1, 1'b0);
    push_data(8'h02);
    slot(1'b0, 1'b1, 1'b1);
    chk("latency_vld_02", 32'(bus.O_vld), 32'd1);
    chk("normal_err_cnt", 32'(bus.err_cnt), 32'd0);

    // Bypass: bit lands on O[1]
    @(negedge clk);
    bus.bypass = 1'b1;
    push_data(8'h02);
    slot(1'b1, 1'b1, 1'b1);
    chk("bypass_vld", 32'(bus.O_vld), 32'd1);
    push_data(8'h00);
    slot(1'b1, 1'b1, 1'b0);
    chk("bypass_O0", 32'(bus.O), 32'h00);
    @(negedge clk);
    bus.bypass = 1'b0;
    chk("bypass_err_cnt", 32'(bus.err_cnt), 32'd0);

    // Misalignment: lone mid-period sample from IDLE
    push_err();
    slot(1'b0, 1'b1, 1'b1);
    chk("misalign_err", 32'(bus.err), 32'd1);
    chk("misalign_err_cnt", 32'(bus.err_cnt), 32'd1);
    chk("misalign_no_vld", 32'(bus.O_vld), 32'd0);
    slot(1'b1, 1'b1, 1'b1);
    push_data(8'h03);
    slot(1'b0, 1'b1, 1'b1);
    chk("realign_err_cnt", 32'(bus.err_cnt), 32'd1);

    // Dropout: start then ce_2M with I_vld=0
    slot(1'b1, 1'b1, 1'b0);
    push_err();
    slot(1'b0, 1'b0, 1'b1);
    chk("dropout_no_vld", 32'(bus.O_vld), 32'd0);
    chk("dropout_O_held", 32'(bus.O), 32'h03);
    chk("dropout_err_cnt", 32'(bus.err_cnt), 32'd2);
    slot(1'b1, 1'b1, 1'b0);
    push_data(8'h02);
    slot(1'b0, 1'b1, 1'b1);

    // Saturation: five more errors on a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      push_err();
      slot(1'b0, 1'b1, 1'b0);
    end
    chk("sat_err_cnt", 32'(bus.err_cnt), 32'd3);

    // Reset while collecting
    slot(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_O", 32'(bus.O), 32'h00);
    chk("midrst_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("midrst_O_vld", 32'(bus.O_vld), 32'd0);
    rst = 1'b0;
    slot(1'b1, 1'b1, 1'b1);
    push_data(8'h03);
    slot(1'b0, 1'b1, 1'b1);
    chk("post_rst_vld", 32'(bus.O_vld), 32'd1);
    repeat (40) @(negedge clk);
    chk("post_rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
